// File: rtl/if_stage_fetch_unit.sv
// Instruction-fetch stage: owns the program counter and the IF/ID pipeline register,
// and keeps saturating counters of flush bubbles and stall cycles.
module if_stage_fetch_unit #(
    parameter logic [31:0] RESET_PC  = 32'h0040_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0000,
    parameter int unsigned CNT_W     = 32
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_stall,
    input  logic             i_IF_ID_Flush,
    input  logic             i_Jump,
    input  logic [31:0]      i_jump_target,
    input  logic             i_branch_taken,
    input  logic [31:0]      i_branch_target,
    input  logic [31:0]      i_instr,
    output logic [31:0]      o_pc,
    output logic [31:0]      o_IF_ID_instr,
    output logic [31:0]      o_IF_ID_pc_plus4,
    output logic             o_IF_ID_valid,
    output logic [CNT_W-1:0] o_flush_count,
    output logic [CNT_W-1:0] o_stall_count
);

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic [31:0] pc_plus4;
    logic [31:0] next_pc;
    logic        flush_evt;
    logic        stall_evt;

    assign pc_plus4 = o_pc + 32'd4;

    // A taken branch beats a stall; a stall masks both the jump and the flush request.
    always_comb begin
        next_pc   = pc_plus4;
        flush_evt = 1'b0;
        stall_evt = 1'b0;
        if (i_branch_taken) begin
            next_pc   = {i_branch_target[31:2], 2'b00};
            flush_evt = 1'b1;
        end else if (i_stall) begin
            next_pc   = o_pc;
            stall_evt = 1'b1;
        end else begin
            if (i_Jump) begin
                next_pc = {i_jump_target[31:2], 2'b00};
            end
            flush_evt = i_IF_ID_Flush;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            o_pc <= RESET_PC;
        end else begin
            o_pc <= next_pc;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            o_IF_ID_instr    <= NOP_INSTR;
            o_IF_ID_pc_plus4 <= 32'd0;
            o_IF_ID_valid    <= 1'b0;
        end else if (flush_evt) begin
            o_IF_ID_instr    <= NOP_INSTR;
            o_IF_ID_pc_plus4 <= 32'd0;
            o_IF_ID_valid    <= 1'b0;
        end else if (!stall_evt) begin
            o_IF_ID_instr    <= i_instr;
            o_IF_ID_pc_plus4 <= pc_plus4;
            o_IF_ID_valid    <= 1'b1;
        end
    end

    // Counters stick at all-ones rather than wrapping.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            o_flush_count <= '0;
            o_stall_count <= '0;
        end else begin
            if (flush_evt && (o_flush_count != CNT_MAX)) begin
                o_flush_count <= o_flush_count + CNT_ONE;
            end
            if (stall_evt && (o_stall_count != CNT_MAX)) begin
                o_stall_count <= o_stall_count + CNT_ONE;
            end
        end
    end

endmodule
